// File: rtl/uart_bus_host.sv
// UART-to-bus bridge: 8N1 command frames on rx_i become single 32-bit bus
// transactions; status and read data are returned serially on tx_o.
module uart_bus_host #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_addr_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        busy_o
);
    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_REQ, P_WAIT, P_RESP} p_state_t;

    logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic            rx_strobe_q, rx_strobe_d, rx_ferr_q, rx_ferr_d;

    p_state_t        p_state_q, p_state_d;
    logic [1:0]      p_cnt_q, p_cnt_d;
    logic            is_write_q, is_write_d;
    logic [31:0]     asm_q, asm_d, addr_q, addr_d, wdata_q, wdata_d;
    logic            req_q, req_d, we_q, we_d, busy_q, busy_d;
    logic [3:0]      be_q, be_d;

    logic            tx_q, tx_d, tx_active_q, tx_active_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [39:0]     tx_buf_q, tx_buf_d;
    logic [2:0]      tx_left_q, tx_left_d;
    logic            tx_load, tx_finish;

    always_comb begin
        rx_meta_d   = rx_i;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        rx_ferr_d   = 1'b0;
        p_state_d   = p_state_q;
        p_cnt_d     = p_cnt_q;
        is_write_d  = is_write_q;
        asm_d       = asm_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_d       = req_q;
        we_d        = we_q;
        be_d        = be_q;
        busy_d      = busy_q;
        tx_d        = tx_q;
        tx_active_d = tx_active_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        tx_buf_d    = tx_buf_q;
        tx_left_d   = tx_left_q;
        tx_load     = 1'b0;
        tx_finish   = 1'b0;

        // Receiver: start detected on a falling edge, confirmed at half-bit.
        case (rx_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d  = R_IDLE;
                    rx_strobe_d = rx_sync_q;
                    rx_ferr_d   = !rx_sync_q;
                    rx_byte_d   = rx_shift_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase

        // Transmitter: drains tx_buf_q byte by byte with no gap between frames.
        if (!tx_active_q) begin
            tx_load = (tx_left_q != 3'd0);
        end else if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
                if (tx_left_q != 3'd0) begin
                    tx_load = 1'b1;
                end else begin
                    tx_active_d = 1'b0;
                    tx_finish   = 1'b1;
                end
            end else begin
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q < 4'd8) begin
                    tx_d      = tx_byte_q[0];
                    tx_byte_d = {1'b0, tx_byte_q[7:1]};
                end else begin
                    tx_d = 1'b1;
                end
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
        if (tx_load) begin
            tx_active_d = 1'b1;
            tx_cnt_d    = '0;
            tx_bit_d    = 4'd0;
            tx_d        = 1'b0;
            tx_byte_d   = tx_buf_q[7:0];
            tx_buf_d    = {8'h00, tx_buf_q[39:8]};
            tx_left_d   = tx_left_q - 3'd1;
        end

        case (p_state_q)
            P_IDLE: begin
                if (rx_strobe_q) begin
                    busy_d = 1'b1;
                    if (rx_byte_q == 8'h57 || rx_byte_q == 8'h52) begin
                        is_write_d = (rx_byte_q == 8'h57);
                        p_cnt_d    = 2'd0;
                        p_state_d  = P_ADDR;
                    end else begin
                        tx_buf_d  = {32'h0, 8'h3F};
                        tx_left_d = 3'd1;
                        p_state_d = P_RESP;
                    end
                end
            end
            P_ADDR, P_DATA: begin
                if (rx_ferr_q) begin
                    busy_d    = 1'b0;
                    p_state_d = P_IDLE;
                end else if (rx_strobe_q) begin
                    asm_d   = {rx_byte_q, asm_q[31:8]};
                    p_cnt_d = p_cnt_q + 2'd1;
                    if (p_cnt_q == 2'd3) begin
                        if (p_state_q == P_ADDR) begin
                            addr_d = asm_d;
                        end else begin
                            wdata_d = asm_d;
                        end
                        if (p_state_q == P_ADDR && is_write_q) begin
                            p_state_d = P_DATA;
                        end else begin
                            p_state_d = P_REQ;
                            req_d     = 1'b1;
                            we_d      = is_write_q;
                            be_d      = 4'hF;
                        end
                    end
                end
            end
            P_REQ: begin
                if (host_gnt_i) begin
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    be_d      = 4'h0;
                    p_state_d = P_WAIT;
                end
            end
            P_WAIT: begin
                if (host_rvalid_i) begin
                    if (host_err_i) begin
                        tx_buf_d  = {32'h0, 8'h45};
                        tx_left_d = 3'd1;
                    end else begin
                        tx_buf_d  = {host_rdata_i, 8'h4B};
                        tx_left_d = is_write_q ? 3'd1 : 3'd5;
                    end
                    p_state_d = P_RESP;
                end
            end
            P_RESP: begin
                if (tx_finish) begin
                    busy_d    = 1'b0;
                    p_state_d = P_IDLE;
                end
            end
            default: p_state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= R_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_strobe_q <= 1'b0;
            rx_ferr_q   <= 1'b0;
            p_state_q   <= P_IDLE;
            p_cnt_q     <= 2'd0;
            is_write_q  <= 1'b0;
            asm_q       <= 32'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 4'd0;
            tx_byte_q   <= 8'h00;
            tx_buf_q    <= 40'h0;
            tx_left_q   <= 3'd0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_strobe_q <= rx_strobe_d;
            rx_ferr_q   <= rx_ferr_d;
            p_state_q   <= p_state_d;
            p_cnt_q     <= p_cnt_d;
            is_write_q  <= is_write_d;
            asm_q       <= asm_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            we_q        <= we_d;
            be_q        <= be_d;
            busy_q      <= busy_d;
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            tx_buf_q    <= tx_buf_d;
            tx_left_q   <= tx_left_d;
        end
    end

    assign tx_o         = tx_q;
    assign host_req_o   = req_q;
    assign host_we_o    = we_q;
    assign host_be_o    = be_q;
    assign host_addr_o  = addr_q;
    assign host_wdata_o = wdata_q;
    assign busy_o       = busy_q;
endmodule

// File: doc/uart_bus_host.md
# uart_bus_host

- Serial-to-bus bridge: a host PC drives the system bus through the UART pins.
- Receives 8N1 command frames on `rx_i` and issues single 32-bit read/write transactions as a bus initiator on the same req/gnt/rvalid interface that the LSU uses to reach peripherals such as the UART register block.
- Returns status and read data serially on `tx_o`.
- Sits alongside the core as a second bus host, used for program loading and debug peek/poke.

## Interface

Parameters:
- `CLOCK_FREQUENCY`, 50_000_000: `clk_i` frequency in Hz.
- `BAUD_RATE`, 115200: fixed line rate. `CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE` (integer division, must be ≥ 4).

Ports:
- One clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `rx_i` in 1: serial input, asynchronous to `clk_i`, idle high.
- `tx_o` out 1: serial output, idle high.
- `host_req_o` out 1: bus request.
- `host_gnt_i` in 1: bus grant.
- `host_we_o` out 1: 1 = write, 0 = read.
- `host_be_o` out 4: byte enables; always 4'hF during a request.
- `host_addr_o` out 32: address.
- `host_wdata_o` out 32: write data.
- `host_rvalid_i` in 1: response valid.
- `host_rdata_i` in 32: read data.
- `host_err_i` in 1: response error; qualified by `host_rvalid_i`.
- `busy_o` out 1: high from opcode byte accepted until last response stop bit sent.

## Operation

**Receiver**
- `rx_i` passes through a 2-flop synchronizer.
- Falling edge in IDLE starts a byte. The line is re-checked at CLKS_PER_BIT/2; if high, the start is a glitch: discard and return to idle.
- 8 data bits, LSB first, each sampled CLKS_PER_BIT after the previous sample.
- Stop bit sampled 1 bit later. Stop = 0 is a framing error: the byte is discarded and the parser returns to P_IDLE silently.
- A good byte produces a 1-cycle internal strobe.

**Transmitter**
- Sends a start bit (0), 8 data bits LSB first, then a stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- A new byte may begin the cycle after the previous stop bit ends.

**Parser FSM**
- P_IDLE:
  - 0x57 'W' → P_ADDR (write).
  - 0x52 'R' → P_ADDR (read).
  - Any other byte → send 0x3F '?' and stay in P_IDLE. `busy_o` is high for the duration of the '?' byte.
- P_ADDR: 4 bytes, LSB first, assembled into addr.
  - Write → P_DATA.
  - Read → P_REQ.
- P_DATA: 4 bytes, LSB first, assembled into wdata → P_REQ.
- P_REQ: `host_req_o` = 1 with addr/we/be/wdata stable; held until `host_gnt_i` is sampled 1. `host_req_o` drops the following cycle → P_WAIT.
- P_WAIT: waits for `host_rvalid_i`, sampled only in cycles after the grant cycle. Captures `host_rdata_i` and `host_err_i`.
  - err = 1 → send 0x45 'E'.
  - Otherwise send 0x4B 'K'.
  - For a read, 'K' is followed by 4 data bytes, LSB first. An 'E' on a read sends no data.
- P_RESP: waits until the last response byte's stop bit completes → P_IDLE.

**Other rules**
- Bytes received while `busy_o` = 1 (other than the in-progress command bytes) are discarded.
- There is no inter-byte timeout; a partial frame waits indefinitely.
- `host_addr_o` and `host_wdata_o` hold their last values when idle. `host_we_o` is 0 outside P_REQ.

## Timing

- Reset values:
  - `tx_o` = 1; `host_req_o` = 0; `host_we_o` = 0; `host_be_o` = 0; `host_addr_o` = 0; `host_wdata_o` = 0; `busy_o` = 0.
  - Parser in P_IDLE; RX and TX counters cleared.
- Reset asserted mid-frame or mid-transaction returns everything to the reset state immediately, including dropping `host_req_o`. Any outstanding bus response is ignored after reset.
- Receive latency: the byte strobe fires 2 (synchronizer) + 9.5·CLKS_PER_BIT (±1) cycles after the start-bit falling edge.
- `host_req_o` rises within 2 cycles of the final command byte's strobe.
- A grant in the same cycle as request assertion is legal; the transaction then lasts 1 request cycle.
- The response start bit (`tx_o` falling) begins within 2 cycles of `host_rvalid_i` being sampled.
- Back-to-back read response bytes have no idle gap between stop and start.
- `busy_o` falls the cycle after the final stop bit ends.

## Test plan

Use CLOCK_FREQUENCY = 1_000_000 and BAUD_RATE = 100_000 (CLKS_PER_BIT = 10).

1. **Write:** send 57 78 56 34 12 EF BE AD DE; bench grants after 3 cycles, then rvalid = 1, err = 0.
   - Required: one request with addr 0x12345678, wdata 0xDEADBEEF, we = 1, be = F.
   - `tx_o` returns 4B.
2. **Read:** send 52 00 10 00 00; bench grants the same cycle and returns rdata 0xCAFEF00D.
   - Required: `tx_o` returns 4B 0D F0 FE CA contiguously; `busy_o` falls after the last stop bit.
3. **Error:** read at 0x20, bench returns rvalid with err = 1.
   - Required: single byte 45 and no data bytes.
4. **Grant stall:** hold gnt = 0 for 50 cycles.
   - Required: `host_req_o`, addr, we and wdata stay stable all 50 cycles; exactly one transaction occurs.
5. **Line faults:**
   - 3-cycle low glitch on `rx_i` → no byte.
   - Byte with stop = 0 mid-address → parser back in P_IDLE.
   - A following valid 41 → response 3F.
6. **Reset mid-transaction:** assert `rst_ni` low while in P_REQ and during a TX byte.
   - Required: `host_req_o` = 0 and `tx_o` = 1 immediately.
   - A fresh write command afterwards completes normally.
